multicycle_control_unit: RTL

Multi-cycle successor to the single-cycle opcode decoder. It sequences each MIPS-basic instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the datapath enables from the current state and a latched opcode. It waits on instruction- and data-memory ready handshakes, bounded by a parametrised timeout. Illegal opcodes and memory timeouts are trapped. It sits between the instruction register and the existing datapath (register file, ALU, PC mux, data memory).

---
 rtl/multicycle_control_unit.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS-basic control unit: sequences FETCH/DECODE/EXEC/MEM/WB,
// waits on memory ready handshakes with a bounded wait counter, traps illegal ops and timeouts.
module multicycle_control_unit #(
    parameter int ALUOP_W  = 3,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               instr_ready,
    input  logic               mem_ready,
    input  logic               zero,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               ir_write,
    output logic               instr_read,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_byte,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         wb_sel,
    output logic               alu_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [2:0]         state_o,
    output logic               instr_done,
    output logic               trap,
    output logic [1:0]         trap_cause
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_ADDI = 6'b000010, OP_SUBI = 6'b000011,
                           OP_ANDI  = 6'b000100, OP_ORI  = 6'b000101, OP_SLTI = 6'b000111,
                           OP_LW    = 6'b001000, OP_LB   = 6'b001001, OP_SW   = 6'b010000,
                           OP_SB    = 6'b010001, OP_BEQ  = 6'b100011, OP_BNE  = 6'b100111,
                           OP_J     = 6'b111000, OP_JAL  = 6'b111001, OP_MOVE = 6'b100000;

    localparam logic [ALUOP_W-1:0] ALUOP_AND   = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALUOP_OR    = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = ALUOP_W'(3'b011);
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = ALUOP_W'(3'b110);
    localparam logic [ALUOP_W-1:0] ALUOP_LESS  = ALUOP_W'(3'b111);

    localparam logic [CNT_W-1:0] WCNT_LAST = CNT_W'(WAIT_MAX - 1);

    state_t           state;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] wcnt;
    logic [1:0]       cause_q;

    function automatic logic goes_to_exec(input logic [5:0] o);
        case (o)
            OP_RTYPE, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SLTI,
            OP_LW, OP_LB, OP_SW, OP_SB, OP_BEQ, OP_BNE, OP_J, OP_JAL: goes_to_exec = 1'b1;
            default:                                                   goes_to_exec = 1'b0;
        endcase
    endfunction

    function automatic logic [ALUOP_W-1:0] imm_alu_op(input logic [5:0] o);
        case (o)
            OP_SUBI: imm_alu_op = ALUOP_SUB;
            OP_ANDI: imm_alu_op = ALUOP_AND;
            OP_ORI:  imm_alu_op = ALUOP_OR;
            OP_SLTI: imm_alu_op = ALUOP_LESS;
            default: imm_alu_op = ALUOP_ADD;
        endcase
    endfunction

    logic is_rtype, is_ialu, is_load, is_store, is_byte, is_beq, is_bne, is_j, is_jal, is_move;
    assign is_rtype = (op_q == OP_RTYPE);
    assign is_ialu  = (op_q == OP_ADDI) || (op_q == OP_SUBI) || (op_q == OP_ANDI) ||
                      (op_q == OP_ORI)  || (op_q == OP_SLTI);
    assign is_load  = (op_q == OP_LW) || (op_q == OP_LB);
    assign is_store = (op_q == OP_SW) || (op_q == OP_SB);
    assign is_byte  = (op_q == OP_LB) || (op_q == OP_SB);
    assign is_beq   = (op_q == OP_BEQ);
    assign is_bne   = (op_q == OP_BNE);
    assign is_j     = (op_q == OP_J);
    assign is_jal   = (op_q == OP_JAL);
    assign is_move  = (op_q == OP_MOVE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            op_q    <= '0;
            wcnt    <= '0;
            cause_q <= 2'd0;
        end else begin
            case (state)
                S_FETCH: begin
                    // Ready wins over the timeout when both happen in the same cycle.
                    if (instr_ready) begin
                        state <= S_DECODE;
                        wcnt  <= '0;
                    end else if (wcnt == WCNT_LAST) begin
                        state   <= S_TRAP;
                        cause_q <= 2'd2;
                        wcnt    <= '0;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    op_q <= opcode;
                    wcnt <= '0;
                    if (opcode == OP_MOVE) begin
                        state <= S_WB;
                    end else if (goes_to_exec(opcode)) begin
                        state <= S_EXEC;
                    end else begin
                        state   <= S_TRAP;
                        cause_q <= 2'd1;
                    end
                end
                S_EXEC: begin
                    wcnt <= '0;
                    if (is_load || is_store)      state <= S_MEM;
                    else if (is_rtype || is_ialu) state <= S_WB;
                    else                          state <= S_FETCH;
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state <= is_load ? S_WB : S_FETCH;
                        wcnt  <= '0;
                    end else if (wcnt == WCNT_LAST) begin
                        state   <= S_TRAP;
                        cause_q <= 2'd2;
                        wcnt    <= '0;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_WB: begin
                    state <= S_FETCH;
                    wcnt  <= '0;
                end
                S_TRAP:  state <= S_TRAP;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Output decode; everything is held at zero while rst is asserted.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        ir_write   = 1'b0;
        instr_read = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_byte   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'd0;
        wb_sel     = 2'd0;
        alu_src    = 1'b0;
        alu_op     = '0;
        state_o    = 3'd0;
        instr_done = 1'b0;
        trap       = 1'b0;
        trap_cause = 2'd0;
        if (!rst) begin
            state_o = state;
            case (state)
                S_FETCH: begin
                    instr_read = 1'b1;
                    ir_write   = instr_ready;
                    pc_write   = instr_ready;
                end
                S_EXEC: begin
                    if (is_rtype) begin
                        alu_op = ALUOP_RTYPE;
                    end else if (is_ialu) begin
                        alu_op  = imm_alu_op(op_q);
                        alu_src = 1'b1;
                    end else if (is_load || is_store) begin
                        alu_op  = ALUOP_ADD;
                        alu_src = 1'b1;
                    end else if (is_beq || is_bne) begin
                        alu_op     = ALUOP_SUB;
                        pc_src     = 2'd1;
                        pc_write   = is_beq ? zero : !zero;
                        instr_done = 1'b1;
                    end else if (is_j || is_jal) begin
                        pc_write   = 1'b1;
                        pc_src     = 2'd2;
                        instr_done = 1'b1;
                        if (is_jal) begin
                            reg_write = 1'b1;
                            reg_dst   = 2'd2;
                            wb_sel    = 2'd2;
                        end
                    end
                end
                S_MEM: begin
                    mem_read   = is_load;
                    mem_write  = is_store;
                    mem_byte   = is_byte;
                    instr_done = is_store && mem_ready;
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    reg_dst    = is_rtype ? 2'd1 : 2'd0;
                    wb_sel     = is_load ? 2'd1 : (is_move ? 2'd3 : 2'd0);
                end
                S_TRAP: begin
                    trap       = 1'b1;
                    trap_cause = cause_q;
                end
                default: ;
            endcase
        end
    end

endmodule
